// File: rtl/hash_result_tx.sv
// Holds the last scrypt result {hash, nonce} and streams it as a 36-byte frame on a valid/ack byte port.
// tx_valid rises 1 cycle after tx_request (2 when it coincides with hash_done); tx_data holds until tx_ack.
module hash_result_tx #(
  parameter int          HASH_BYTES  = 32,
  parameter int          NONCE_BYTES = 4,
  parameter logic [7:0]  NORES_BYTE  = 8'hEE
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      hash_done,
  input  logic [8*HASH_BYTES-1:0]   scrypt_hash,
  input  logic [8*NONCE_BYTES-1:0]  nonce,
  input  logic                      tx_request,
  input  logic                      tx_abort,
  input  logic                      tx_ack,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  output logic                      result_ready,
  output logic                      busy,
  output logic                      overrun
);

  localparam int          FRAME_BYTES = HASH_BYTES + NONCE_BYTES;
  localparam int          SW          = 8 * FRAME_BYTES;
  localparam logic [5:0]  LAST_IDX    = 6'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, NORES} state_t;

  state_t          state_q, state_d;
  logic [5:0]      idx_q, idx_d;
  logic [SW-1:0]   shadow_q, shadow_d;
  logic            rdy_q, rdy_d;
  logic            ovr_q, ovr_d;
  logic            pend_q, pend_d;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      rdy_q    <= 1'b0;
      ovr_q    <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      rdy_q    <= rdy_d;
      ovr_q    <= ovr_d;
      pend_q   <= pend_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    rdy_d    = rdy_q;
    ovr_d    = ovr_q;
    pend_d   = pend_q;
    case (state_q)
      IDLE: begin
        if (hash_done) begin
          shadow_d = {scrypt_hash, nonce};
          rdy_d    = 1'b1;
          if (rdy_q) ovr_d = 1'b1;
        end
        // A request coinciding with a capture is deferred one cycle so it reads the new data.
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = SEND;
          idx_d   = '0;
        end else if (tx_request) begin
          if (hash_done) begin
            pend_d = 1'b1;
          end else if (rdy_q) begin
            state_d = SEND;
            idx_d   = '0;
          end else begin
            state_d = NORES;
          end
        end
      end
      SEND: begin
        if (tx_abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tx_ack) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            rdy_d   = 1'b0;
            ovr_d   = 1'b0;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end
        if (hash_done) ovr_d = 1'b1;
      end
      NORES: begin
        if (tx_abort || tx_ack) state_d = IDLE;
        if (hash_done) ovr_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    case (state_q)
      SEND: begin
        tx_data  = shadow_q[{idx_q, 3'b000} +: 8];
        tx_valid = 1'b1;
      end
      NORES: begin
        tx_data  = NORES_BYTE;
        tx_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign result_ready = rdy_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_hash_result_tx.sv
module tb_hash_result_tx;
  logic         clk = 1'b0;
  logic         n_rst;
  logic         hash_done;
  logic [255:0] scrypt_hash;
  logic [31:0]  nonce;
  logic         tx_request, tx_abort, tx_ack;
  logic [7:0]   tx_data;
  logic         tx_valid, result_ready, busy, overrun;

  int vectors    = 0;
  int miscompares = 0;

  logic [255:0] h1, h2;
  logic [31:0]  n1, n2, n3;

  hash_result_tx dut (
    .clk(clk), .n_rst(n_rst), .hash_done(hash_done), .scrypt_hash(scrypt_hash),
    .nonce(nonce), .tx_request(tx_request), .tx_abort(tx_abort), .tx_ack(tx_ack),
    .tx_data(tx_data), .tx_valid(tx_valid), .result_ready(result_ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Frame byte i: four nonce bytes LSB first, then hash bytes LSB first.
  function automatic logic [7:0] exp_byte(input logic [255:0] h, input logic [31:0] n, input int i);
    if (i < 4) return n[8*i +: 8];
    return h[8*(i-4) +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    hash_done = 1'b0; tx_request = 1'b0; tx_abort = 1'b0; tx_ack = 1'b0;
    scrypt_hash = '0; nonce = '0;
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic load(input logic [255:0] h, input logic [31:0] n);
    scrypt_hash = h; nonce = n; hash_done = 1'b1;
    tick();
    hash_done = 1'b0;
  endtask

  task automatic request();
    tx_request = 1'b1;
    tick();
    tx_request = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    hash_done = 1'b0; tx_request = 1'b0; tx_abort = 1'b0; tx_ack = 1'b0;
    scrypt_hash = '0; nonce = '0;
    #1;
    vectors++;
    if ({tx_data, tx_valid, result_ready, busy, overrun} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=000", {tx_data, tx_valid, result_ready, busy, overrun});
    end
    tick();
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_capture_read();
    logic [7:0] want [36];
    for (int i = 0; i < 36; i++) want[i] = 8'h00;
    want[0] = 8'h78; want[1] = 8'h56; want[2] = 8'h34; want[3] = 8'h12; want[4] = 8'h1F;
    load(h1, n1);
    vectors++;
    if (result_ready !== 1'b1 || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL capture_flags rr=%b valid=%b want rr=1 valid=0", result_ready, tx_valid);
    end
    request();
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== want[i] || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL read_byte[%0d] valid=%b data=%h busy=%b want valid=1 data=%h busy=1", i, tx_valid, tx_data, busy, want[i]);
      end
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || result_ready !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_end valid=%b rr=%b busy=%b want 0 0 0", tx_valid, result_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    load(h2, n2);
    request();
    for (int i = 0; i < 36; i++) begin
      if (i == 10) begin
        for (int k = 0; k < 5; k++) begin
          vectors++;
          if (tx_valid !== 1'b1 || tx_data !== 8'h46) begin
            miscompares++;
            $display("FAIL bp_hold[%0d] valid=%b data=%h want valid=1 data=46", k, tx_valid, tx_data);
          end
          tick();
        end
      end
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp_byte(h2, n2, i)) begin
        miscompares++;
        $display("FAIL bp_byte[%0d] valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_byte(h2, n2, i));
      end
      tx_ack = 1'b1;
      tick();
      tx_ack = 1'b0;
      if (i == 10) begin
        vectors++;
        if (tx_data !== 8'h47 || tx_valid !== 1'b1) begin
          miscompares++;
          $display("FAIL bp_next data=%h valid=%b want data=47 valid=1", tx_data, tx_valid);
        end
      end
    end
    vectors++;
    if (tx_valid !== 1'b0 || result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_end valid=%b rr=%b want 0 0", tx_valid, result_ready);
    end
  endtask

  task automatic test_nores();
    do_reset();
    request();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE || busy !== 1'b1 || result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL nores_byte valid=%b data=%h busy=%b rr=%b want 1 ee 1 0", tx_valid, tx_data, busy, result_ready);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL nores_end valid=%b busy=%b rr=%b want 0 0 0", tx_valid, busy, result_ready);
    end
  endtask

  task automatic test_abort_retry();
    load(h1, n1);
    request();
    for (int i = 0; i < 20; i++) begin
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
    vectors++;
    if (tx_data !== exp_byte(h1, n1, 20)) begin
      miscompares++;
      $display("FAIL abort_pre data=%h want %h", tx_data, exp_byte(h1, n1, 20));
    end
    tx_abort = 1'b1; tx_ack = 1'b1;
    tick();
    tx_abort = 1'b0; tx_ack = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0 || result_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_state valid=%b rr=%b busy=%b want 0 1 0", tx_valid, result_ready, busy);
    end
    request();
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp_byte(h1, n1, i)) begin
        miscompares++;
        $display("FAIL retry_byte[%0d] valid=%b data=%h want valid=1 data=%h", i, tx_valid, tx_data, exp_byte(h1, n1, i));
      end
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    load(h1, n1);
    load(h2, n3);
    vectors++;
    if (overrun !== 1'b1 || result_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_double ovr=%b rr=%b want 1 1", overrun, result_ready);
    end
    request();
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp_byte(h2, n3, i)) begin
        miscompares++;
        $display("FAIL ovr_byte[%0d] data=%h want %h", i, tx_data, exp_byte(h2, n3, i));
      end
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_cleared ovr=%b want 0", overrun);
    end
    // A result arriving mid-frame must not disturb the bytes being sent.
    load(h1, n1);
    request();
    tx_ack = 1'b1; tick(); tick(); tx_ack = 1'b0;
    load(h2, n2);
    vectors++;
    if (overrun !== 1'b1 || tx_data !== 8'h34 || tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL send_drop ovr=%b data=%h valid=%b want 1 34 1", overrun, tx_data, tx_valid);
    end
    for (int i = 2; i < 36; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp_byte(h1, n1, i)) begin
        miscompares++;
        $display("FAIL send_drop_byte[%0d] data=%h want %h", i, tx_data, exp_byte(h1, n1, i));
      end
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
  endtask

  task automatic test_simultaneous();
    do_reset();
    scrypt_hash = h2; nonce = n2; hash_done = 1'b1; tx_request = 1'b1;
    tick();
    hash_done = 1'b0; tx_request = 1'b0;
    tick();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
      miscompares++;
      $display("FAIL simul_first valid=%b data=%h want valid=1 data=ef", tx_valid, tx_data);
    end
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== exp_byte(h2, n2, i)) begin
        miscompares++;
        $display("FAIL simul_byte[%0d] data=%h want %h", i, tx_data, exp_byte(h2, n2, i));
      end
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
  endtask

  task automatic test_reset_midframe();
    load(h1, n1);
    request();
    for (int i = 0; i < 15; i++) begin
      tx_ack = 1'b1;
      tick();
    end
    tx_ack = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    vectors++;
    if ({tx_data, tx_valid, result_ready, busy, overrun} !== 12'h000) begin
      miscompares++;
      $display("FAIL midreset_outputs got=%h want=000", {tx_data, tx_valid, result_ready, busy, overrun});
    end
    tick();
    n_rst = 1'b1;
    tick();
    request();
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEE) begin
      miscompares++;
      $display("FAIL midreset_nores valid=%b data=%h want 1 ee", tx_valid, tx_data);
    end
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  initial begin
    h1 = 256'h1F;
    n1 = 32'h12345678;
    for (int k = 0; k < 32; k++) h2[8*k +: 8] = 8'h40 + 8'(k);
    n2 = 32'hDEADBEEF;
    n3 = 32'hCAFEF00D;
    test_reset();
    test_capture_read();
    test_backpressure();
    test_nores();
    test_abort_retry();
    test_overrun();
    test_simultaneous();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hash_result_tx.md
Name: hash_result_tx

Overview:
- Transmit-side counterpart of the byte-wise header loader.
- Captures the 256-bit scrypt hash and its 32-bit nonce when the hasher signals completion.
- On host request, streams the result one byte at a time to the I2C transceiver's transmit path using a valid/ack handshake.
- Sits between the scrypt core (hash_done, hash, nonce) and the i2c transceiver; the main controller sees result_ready and busy.

Parameters:
HASH_BYTES, 32, number of hash bytes sent per frame (hash width = 8*HASH_BYTES)
NONCE_BYTES, 4, number of nonce bytes sent ahead of the hash (nonce width = 8*NONCE_BYTES)
NORES_BYTE, 8'hEE, single byte returned when a request arrives with no result stored

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
hash_done  in  1  one-cycle pulse: scrypt_hash and nonce are valid this cycle
scrypt_hash  in  256  completed hash
nonce  in  32  nonce that produced scrypt_hash
tx_request  in  1  one-cycle pulse: host issued a read-result command
tx_abort  in  1  host NACK/STOP mid-frame; abandon the current frame
tx_ack  in  1  transceiver consumed tx_data this cycle
tx_data  out  8  byte being offered
tx_valid  out  1  tx_data is valid
result_ready  out  1  an unread result is held in the shadow register
busy  out  1  a frame is in progress
overrun  out  1  sticky: a result was lost or overwritten before being read

Behaviour:
- Reset (async, n_rst=0) clears all state. tx_data=0, tx_valid=0, result_ready=0, busy=0, overrun=0, state=IDLE, byte index=0, req_pending=0.
- Shadow register is 288 bits: {scrypt_hash, nonce}.
- Frame order, 36 bytes:
  - Bytes 0..3: nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24].
  - Bytes 4..35: hash[7:0] up to hash[255:248].
- States are IDLE, SEND and NORES.
- IDLE:
  - hash_done captures the shadow register and sets result_ready=1. If result_ready was already 1, also set overrun=1.
  - tx_request with result_ready=1: go to SEND, index=0.
  - tx_request with result_ready=0: go to NORES.
  - tx_valid rises on the cycle after the request (1-cycle latency). busy=1 in SEND and NORES.
  - hash_done and tx_request in the same cycle: the capture happens, the request sets req_pending, and the request is serviced next cycle as a SEND of the new data.
- SEND:
  - tx_data = shadow byte[index]. tx_valid=1.
  - tx_data must stay stable while tx_valid=1 and tx_ack=0.
  - tx_ack on index<35: increment index; the next byte appears the following cycle, with tx_valid held high.
  - tx_ack on index=35: go to IDLE, tx_valid=0, result_ready=0, overrun cleared, index=0.
  - tx_ack while tx_valid=0 is ignored.
- NORES: tx_data=NORES_BYTE, tx_valid=1. tx_ack returns to IDLE.
- Abort and new results during a frame:
  - tx_abort in SEND or NORES: go to IDLE next cycle, tx_valid=0, index=0. result_ready is unchanged, so the host can re-read from byte 0.
  - tx_abort and tx_ack in the same cycle: abort wins.
  - hash_done during SEND or NORES: the result is dropped, the shadow register is unchanged, and overrun=1.
- tx_request outside IDLE is ignored.
- Index width is 6 bits and never exceeds 35; there is no wrap past the frame end.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded.

Test Plan:
- Capture and read: nonce=32'h12345678, hash=256'h00..01F, then tx_request; ack every cycle. Required: 36 bytes 78,56,34,12,1F,00…00. tx_valid drops after the 36th ack. result_ready falls at the same time.
- Backpressure: hold tx_ack=0 for 5 cycles at index 10. Required: tx_data constant and tx_valid=1 throughout; index 11 appears one cycle after the ack.
- No result: tx_request after reset. Required: single byte 8'hEE, then IDLE; result_ready stays 0.
- Abort and retry: tx_abort at index 20. Required: tx_valid=0 next cycle and result_ready=1. A new tx_request restarts at byte 0 (8'h78).
- Overrun and simultaneity:
  - Two hash_done pulses with no read: overrun=1, and the frame carries the second nonce.
  - hash_done during SEND: data unchanged, overrun=1.
  - hash_done and tx_request in the same cycle: the frame carries the new data.
- Async reset asserted at index 15: all outputs 0 immediately. After release, tx_request yields 8'hEE.
